// File: rtl/riscv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_pkg: shared RV32 constants and fetch-cycle classification       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package riscv_pkg;

  localparam int unsigned      XLEN             = 32;
  localparam logic [XLEN-1:0]  NOP_INSTR        = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [XLEN-1:0]  RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    CYC_HOLD     = 3'd0,
    CYC_REDIRECT = 3'd1,
    CYC_FLUSH    = 3'd2,
    CYC_WAIT     = 3'd3,
    CYC_NORMAL   = 3'd4
  } fetch_cycle_e;

endpackage
`default_nettype wire

// File: rtl/if_id_register.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_id_register: IF/ID pipeline latch with hold and bubble insertion   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module if_id_register
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic            bubble_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pc_plus4_i,
  input  logic [XLEN-1:0] instr_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [XLEN-1:0] instr_o,
  output logic            valid_o
);

  logic [XLEN-1:0] pc_q, pc_plus4_q, instr_q;
  logic            valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      pc_plus4_q <= RESET_PC + 32'd4;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
    end else if (we_i) begin
      // A bubble still records the PC so later stages see a coherent address.
      pc_q       <= pc_i;
      pc_plus4_q <= pc_plus4_i;
      instr_q    <= bubble_i ? NOP_INSTR : instr_i;
      valid_q    <= ~bubble_i;
    end
  end

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign instr_o    = instr_q;
  assign valid_o    = valid_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_stage: PC register, fetch classification and IF/ID hand-off    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_write,
  input  logic            if_id_write,
  input  logic            if_id_flush,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_req,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_ready,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic [XLEN-1:0] instr_d,
  output logic            valid_d
);

  logic [XLEN-1:0] pc_q, pc_next_d, pc_plus4, redirect_target;
  fetch_cycle_e    cycle_kind;
  logic            ifid_we, ifid_bubble;

  assign pc_plus4        = pc_q + 32'd4;
  assign redirect_target = redirect_pc & ~32'h0000_0003;

  always_comb begin
    cycle_kind = CYC_NORMAL;
    if (!if_id_write || !pc_write) cycle_kind = CYC_HOLD;
    else if (redirect_valid)       cycle_kind = CYC_REDIRECT;
    else if (if_id_flush)          cycle_kind = CYC_FLUSH;
    else if (!imem_ready)          cycle_kind = CYC_WAIT;
  end

  always_comb begin
    pc_next_d   = pc_q;
    ifid_we     = 1'b1;
    ifid_bubble = 1'b1;
    unique case (cycle_kind)
      CYC_HOLD:     ifid_we   = 1'b0;
      CYC_REDIRECT: pc_next_d = redirect_target;
      CYC_FLUSH:    pc_next_d = imem_ready ? pc_plus4 : pc_q;
      CYC_WAIT:     pc_next_d = pc_q;
      CYC_NORMAL: begin
        pc_next_d   = pc_plus4;
        ifid_bubble = 1'b0;
      end
      default:      pc_next_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_next_d;
  end

  assign imem_addr = pc_q;
  assign imem_req  = rst_n;

  if_id_register #(.RESET_PC(RESET_PC)) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (ifid_we),
    .bubble_i   (ifid_bubble),
    .pc_i       (pc_q),
    .pc_plus4_i (pc_plus4),
    .instr_i    (imem_rdata),
    .pc_o       (pc_d),
    .pc_plus4_o (pc_plus4_d),
    .instr_o    (instr_d),
    .valid_o    (valid_d)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_stage: directed self-checking bench for fetch_stage          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write, if_id_write, if_id_flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] pc_d, pc_plus4_d, instr_d;
  logic        valid_d;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .if_id_flush    (if_id_flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_req       (imem_req),
    .imem_rdata     (imem_rdata),
    .imem_ready     (imem_ready),
    .pc_d           (pc_d),
    .pc_plus4_d     (pc_plus4_d),
    .instr_d        (instr_d),
    .valid_d        (valid_d)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pc_write       = 1'b1;
    if_id_write    = 1'b1;
    if_id_flush    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_ready     = 1'b1;
    imem_rdata     = 32'h0;
  endtask

  task automatic test_reset();
    logic [96:0] exp;
    idle_inputs();
    rst_n = 1'b0;
    pc_write = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h80; if_id_flush = 1'b1;
    tick();
    tick();
    n_checks++;
    if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", imem_addr, 32'h0); end
    n_checks++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
    exp = {32'h0, 32'h4, 32'h13, 1'b0};
    n_checks++;
    if ({pc_d, pc_plus4_d, instr_d, valid_d} !== exp) begin
      n_fail++; $display("FAIL reset_ifid: got %h want %h", {pc_d, pc_plus4_d, instr_d, valid_d}, exp);
    end
    idle_inputs();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b1) begin n_fail++; $display("FAIL req_after_reset: got %b want 1", imem_req); end
  endtask

  task automatic test_sequential();
    logic [31:0] words [3];
    words[0] = 32'hA000_0001; words[1] = 32'hA000_0002; words[2] = 32'hA000_0003;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (imem_addr !== 32'(i * 4)) begin
        n_fail++; $display("FAIL seq_addr%0d: got %h want %h", i, imem_addr, 32'(i * 4));
      end
      imem_rdata = words[i];
      tick();
      n_checks++;
      if ({pc_d, pc_plus4_d, instr_d, valid_d} !== {32'(i * 4), 32'(i * 4 + 4), words[i], 1'b1}) begin
        n_fail++; $display("FAIL seq_ifid%0d: got pc=%h p4=%h ins=%h v=%b want pc=%h ins=%h v=1",
                           i, pc_d, pc_plus4_d, instr_d, valid_d, 32'(i * 4), words[i]);
      end
    end
    // PC now 0xC; one more normal fetch to reach 0x10 happens in test_hold_redirect
  endtask

  task automatic test_mem_wait();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    imem_rdata = 32'h1111_0000; tick(); tick();
    imem_ready = 1'b0; imem_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({imem_addr, pc_d, pc_plus4_d, instr_d, valid_d} !== {32'h8, 32'h8, 32'hC, 32'h13, 1'b0}) begin
        n_fail++; $display("FAIL wait_bubble%0d: got addr=%h pc=%h ins=%h v=%b want addr=8 pc=8 ins=13 v=0",
                           i, imem_addr, pc_d, instr_d, valid_d);
      end
    end
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    n_checks++;
    if ({imem_addr, pc_d, pc_plus4_d, instr_d, valid_d} !== {32'hC, 32'h8, 32'hC, 32'hDEAD_BEEF, 1'b1}) begin
      n_fail++; $display("FAIL wait_release: got addr=%h pc=%h ins=%h v=%b want addr=c pc=8 ins=deadbeef v=1",
                         imem_addr, pc_d, instr_d, valid_d);
    end
  endtask

  task automatic test_hold_redirect();
    imem_rdata = 32'h0000_1111;
    tick();  // fetch from 0xC, PC -> 0x10
    pc_write = 1'b0; if_id_write = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h40; imem_rdata = 32'hBAD1_BAD1;
    tick(); tick();
    n_checks++;
    if ({imem_addr, pc_d, pc_plus4_d, instr_d, valid_d} !== {32'h10, 32'hC, 32'h10, 32'h1111, 1'b1}) begin
      n_fail++; $display("FAIL hold: got addr=%h pc=%h p4=%h ins=%h v=%b want addr=10 pc=c p4=10 ins=1111 v=1",
                         imem_addr, pc_d, pc_plus4_d, instr_d, valid_d);
    end
    pc_write = 1'b1; if_id_write = 1'b1;
    tick();
    n_checks++;
    if ({imem_addr, pc_d, pc_plus4_d, instr_d, valid_d} !== {32'h40, 32'h10, 32'h14, 32'h13, 1'b0}) begin
      n_fail++; $display("FAIL hold_release: got addr=%h pc=%h p4=%h ins=%h v=%b want addr=40 pc=10 p4=14 ins=13 v=0",
                         imem_addr, pc_d, pc_plus4_d, instr_d, valid_d);
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_redirect_flush();
    redirect_valid = 1'b1; redirect_pc = 32'h103; if_id_flush = 1'b1; imem_rdata = 32'hBAD2_BAD2;
    tick();
    n_checks++;
    if ({imem_addr, pc_d, pc_plus4_d, instr_d, valid_d} !== {32'h100, 32'h40, 32'h44, 32'h13, 1'b0}) begin
      n_fail++; $display("FAIL redirect: got addr=%h pc=%h ins=%h v=%b want addr=100 pc=40 ins=13 v=0",
                         imem_addr, pc_d, instr_d, valid_d);
    end
    redirect_valid = 1'b0;
    tick();  // flush with ready: PC advances
    n_checks++;
    if ({imem_addr, pc_d, pc_plus4_d, instr_d, valid_d} !== {32'h104, 32'h100, 32'h104, 32'h13, 1'b0}) begin
      n_fail++; $display("FAIL flush_ready: got addr=%h pc=%h ins=%h v=%b want addr=104 pc=100 ins=13 v=0",
                         imem_addr, pc_d, instr_d, valid_d);
    end
    imem_ready = 1'b0;
    tick();  // flush while waiting: PC holds
    n_checks++;
    if ({imem_addr, pc_d, pc_plus4_d, instr_d, valid_d} !== {32'h104, 32'h104, 32'h108, 32'h13, 1'b0}) begin
      n_fail++; $display("FAIL flush_wait: got addr=%h pc=%h ins=%h v=%b want addr=104 pc=104 ins=13 v=0",
                         imem_addr, pc_d, instr_d, valid_d);
    end
    if_id_flush = 1'b0; imem_ready = 1'b1;
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    n_checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_target: got %h want fffffffc", imem_addr); end
    redirect_valid = 1'b0; imem_rdata = 32'h0000_0055;
    tick();
    n_checks++;
    if ({imem_addr, pc_d, pc_plus4_d, instr_d, valid_d} !== {32'h0, 32'hFFFF_FFFC, 32'h0, 32'h55, 1'b1}) begin
      n_fail++; $display("FAIL wrap: got addr=%h pc=%h p4=%h ins=%h v=%b want addr=0 pc=fffffffc p4=0 ins=55 v=1",
                         imem_addr, pc_d, pc_plus4_d, instr_d, valid_d);
    end
  endtask

  task automatic test_redirect_wait_ready();
    redirect_valid = 1'b1; redirect_pc = 32'h200; imem_rdata = 32'hBAD3_BAD3;
    tick();
    redirect_valid = 1'b0; imem_ready = 1'b0;
    tick();
    n_checks++;
    if ({imem_addr, valid_d, instr_d} !== {32'h200, 1'b0, 32'h13}) begin
      n_fail++; $display("FAIL redir_wait: got addr=%h v=%b ins=%h want addr=200 v=0 ins=13", imem_addr, valid_d, instr_d);
    end
    imem_ready = 1'b1; imem_rdata = 32'h0000_600D;
    tick();
    n_checks++;
    if ({imem_addr, pc_d, pc_plus4_d, instr_d, valid_d} !== {32'h204, 32'h200, 32'h204, 32'h600D, 1'b1}) begin
      n_fail++; $display("FAIL redir_ready: got addr=%h pc=%h ins=%h v=%b want addr=204 pc=200 ins=600d v=1",
                         imem_addr, pc_d, instr_d, valid_d);
    end
  endtask

  task automatic test_reset_during_wait();
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    tick();
    redirect_valid = 1'b0; imem_ready = 1'b0; imem_rdata = 32'hBAD4_BAD4;
    tick();
    rst_n = 1'b0;
    tick();
    n_checks++;
    if ({imem_addr, pc_d, pc_plus4_d, instr_d, valid_d} !== {32'h0, 32'h0, 32'h4, 32'h13, 1'b0}) begin
      n_fail++; $display("FAIL reset_wait: got addr=%h pc=%h ins=%h v=%b want addr=0 pc=0 ins=13 v=0",
                         imem_addr, pc_d, instr_d, valid_d);
    end
    rst_n = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h0000_0077;
    tick();
    n_checks++;
    if ({imem_addr, pc_d, pc_plus4_d, instr_d, valid_d} !== {32'h4, 32'h0, 32'h4, 32'h77, 1'b1}) begin
      n_fail++; $display("FAIL reset_refetch: got addr=%h pc=%h ins=%h v=%b want addr=4 pc=0 ins=77 v=1",
                         imem_addr, pc_d, instr_d, valid_d);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_mem_wait();
    test_hold_redirect();
    test_redirect_flush();
    test_wrap();
    test_redirect_wait_ready();
    test_reset_during_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
